// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory with UART MMIO window:
// store sizes, register offsets and STATUS bit positions.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [31:0] OFF_TXDATA = 32'd0;
  localparam logic [31:0] OFF_RXDATA = 32'd4;
  localparam logic [31:0] OFF_STATUS = 32'd8;
  localparam logic [31:0] WIN_BYTES  = 32'd12;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TXOVF    = 4;
  localparam int ST_RXOVR    = 5;
  localparam int ST_MISALIGN = 6;
  localparam int ST_RXCNT_LO = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head. When empty the head shows the
// most recently popped entry so a stale RXDATA read returns the last byte.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A push into a full FIFO is legal only when the same edge frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = empty ? mem[rd_ptr - AW'(1)] : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Byte-addressable data RAM plus a 3-word UART window (TXDATA, RXDATA, STATUS)
// backed by TX/RX FIFOs, with sticky overflow/misalignment flags and irq.
module data_memory_mmio
  import dmem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_0400,
  parameter int          TX_DEPTH    = 4,
  parameter int          RX_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  irq
);

  localparam int IW  = $clog2(DEPTH_BYTES);
  localparam int TXC = $clog2(TX_DEPTH) + 1;
  localparam int RXC = $clog2(RX_DEPTH) + 1;

  localparam logic [ADDR_WIDTH-1:0] A_TX  = ADDR_WIDTH'(MMIO_BASE + OFF_TXDATA);
  localparam logic [ADDR_WIDTH-1:0] A_RX  = ADDR_WIDTH'(MMIO_BASE + OFF_RXDATA);
  localparam logic [ADDR_WIDTH-1:0] A_ST  = ADDR_WIDTH'(MMIO_BASE + OFF_STATUS);
  localparam logic [ADDR_WIDTH-1:0] A_END = ADDR_WIDTH'(MMIO_BASE + WIN_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [IW-1:0] a0, a1, a2, a3;
  logic          in_win, hit_tx, hit_rx, hit_st;
  logic          misalign_st;

  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [TXC-1:0] tx_count;
  logic          rx_full, rx_empty, rx_pop;
  logic [RXC-1:0] rx_count;
  logic [7:0]    rx_head;

  logic          txovf, rxovr, misalign;
  logic [2:0]    clr;
  logic [31:0]   status;

  assign a0 = addr[IW-1:0];
  assign a1 = a0 + IW'(1);
  assign a2 = a0 + IW'(2);
  assign a3 = a0 + IW'(3);

  assign in_win = (addr >= A_TX) && (addr < A_END);
  assign hit_tx = (addr == A_TX);
  assign hit_rx = (addr == A_RX);
  assign hit_st = (addr == A_ST);

  assign misalign_st = we && !in_win &&
                       ((size == SZ_RSVD) ||
                        (size == SZ_HALF && addr[0]) ||
                        (size == SZ_WORD && addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (we && !in_win && !misalign_st) begin
      mem[a0] <= wd[7:0];
      if (size == SZ_HALF || size == SZ_WORD) mem[a1] <= wd[15:8];
      if (size == SZ_WORD) begin
        mem[a2] <= wd[23:16];
        mem[a3] <= wd[31:24];
      end
    end
  end

  assign tx_push  = we && hit_tx;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;
  assign rx_pop   = re && hit_rx && !rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wd[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Write-1-to-clear; a flag set on the same edge stays set.
  assign clr = (we && hit_st) ? wd[6:4] : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txovf    <= 1'b0;
      rxovr    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      txovf    <= (txovf & ~clr[0]) | (tx_push && tx_full && !tx_pop);
      rxovr    <= (rxovr & ~clr[1]) | (rx_valid && rx_full && !rx_pop);
      misalign <= (misalign & ~clr[2]) | misalign_st;
    end
  end

  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TXOVF]    = txovf;
    status[ST_RXOVR]    = rxovr;
    status[ST_MISALIGN] = misalign;
    status[ST_RXCNT_LO +: 8] = 8'(rx_count);
  end

  always_comb begin
    rd = '0;
    if (hit_rx)       rd = {!rx_empty, 23'b0, rx_head};
    else if (hit_st)  rd = status;
    else if (!in_win) rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end

  assign irq = !rx_empty || txovf || rxovr || misalign;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: expected values are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_data_memory_mmio;

  logic        clk = 1'b0;
  logic        rst_n, we, re, tx_ready, rx_valid;
  logic [1:0]  size;
  logic [31:0] addr, wd, rd;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] TXD = 32'h400;
  localparam logic [31:0] RXD = 32'h404;
  localparam logic [31:0] STS = 32'h408;

  data_memory_mmio dut (
    .clk(clk), .rst_n(rst_n), .we(we), .size(size), .re(re), .addr(addr),
    .wd(wd), .rd(rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected nothing queued", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    addr = a; wd = d; size = s; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] e);
    expect_val(tag, e);
    addr = a; re = 1'b0;
    #1;
    check(rd);
  endtask

  task automatic pop_rx(input string tag, input logic [31:0] e);
    expect_val(tag, e);
    addr = RXD; re = 1'b1;
    #1;
    check(rd);
    tick();
    re = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    size = 2'b00; addr = STS; wd = '0; rx_data = '0;
    #12;
    load_check("reset_status", STS, 32'h0000_0006);
    expect_val("reset_tx_valid", 32'd0); check({31'b0, tx_valid});
    expect_val("reset_tx_data", 32'd0);  check({24'b0, tx_data});
    expect_val("reset_irq", 32'd0);      check({31'b0, irq});
    @(negedge clk); rst_n = 1'b1;
    tick();

    // RAM word/byte/half stores, aliasing and wraparound
    store(32'h10, 32'hDEADBEEF, 2'b10);
    load_check("sw_load", 32'h10, 32'hDEADBEEF);
    store(32'h11, 32'h0000_0055, 2'b00);
    load_check("sb_load", 32'h10, 32'hDEAD55EF);
    load_check("alias_load", 32'h110, 32'hDEAD55EF);
    store(32'h20, 32'h0, 2'b10);
    store(32'h20, 32'hFFFF_1234, 2'b01);
    load_check("sh_load", 32'h20, 32'h0000_1234);
    store(32'hFC, 32'h11223344, 2'b10);
    store(32'h00, 32'hAABBCCDD, 2'b10);
    load_check("wrap_load", 32'hFE, 32'hCCDD1122);
    load_check("window_hole", 32'h401, 32'h0);

    // misaligned and reserved-size stores
    store(32'h12, 32'hFFFF_FFFF, 2'b10);
    load_check("misalign_ram_kept", 32'h10, 32'hDEAD55EF);
    load_check("misalign_status", STS, 32'h0000_0046);
    expect_val("misalign_irq", 32'd1); check({31'b0, irq});
    store(STS, 32'h40, 2'b10);
    load_check("misalign_cleared", STS, 32'h0000_0006);
    expect_val("irq_cleared", 32'd0); check({31'b0, irq});
    store(32'h30, 32'h0, 2'b11);
    load_check("rsvd_size_status", STS, 32'h0000_0046);
    store(STS, 32'h40, 2'b00);

    // TX stream with overflow
    tx_ready = 1'b0;
    store(TXD, 32'h41, 2'b00);
    expect_val("tx_valid_after_store", 32'd1); check({31'b0, tx_valid});
    for (int i = 1; i < 5; i++) store(TXD, 32'h41 + i, 2'b00);
    load_check("tx_overflow_status", STS, 32'h0000_0015);
    load_check("txdata_read_zero", TXD, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_val($sformatf("tx_byte%0d", i), 32'h41 + i);
      check({24'b0, tx_data});
      tick();
    end
    tx_ready = 1'b0;
    expect_val("tx_drained", 32'd0); check({31'b0, tx_valid});
    store(STS, 32'h10, 2'b10);
    load_check("txovf_cleared", STS, 32'h0000_0006);

    // RX overrun and pop sequence
    rx_push(8'h10);
    expect_val("rx_irq", 32'd1); check({31'b0, irq});
    for (int i = 1; i < 5; i++) rx_push(8'h10 + 8'(i));
    load_check("rx_overrun_status", STS, 32'h0000_042A);
    for (int i = 0; i < 4; i++) pop_rx($sformatf("rx_pop%0d", i), 32'h8000_0010 + i);
    pop_rx("rx_pop_empty", 32'h0000_0013);
    load_check("rx_after_drain", STS, 32'h0000_0026);
    store(STS, 32'h20, 2'b10);
    load_check("rxovr_cleared", STS, 32'h0000_0006);

    // simultaneous push and pop while full
    for (int i = 0; i < 4; i++) rx_push(8'h20 + 8'(i));
    rx_data = 8'h99; rx_valid = 1'b1;
    pop_rx("rx_simul_pop", 32'h8000_0020);
    rx_valid = 1'b0;
    load_check("rx_simul_status", STS, 32'h0000_040A);
    for (int i = 1; i < 4; i++) pop_rx($sformatf("rx_simul_drain%0d", i), 32'h8000_0020 + i);
    pop_rx("rx_simul_last", 32'h8000_0099);

    // reset mid-stream
    for (int i = 0; i < 3; i++) store(TXD, 32'h60 + i, 2'b00);
    expect_val("tx_before_reset", 32'd1); check({31'b0, tx_valid});
    #2 rst_n = 1'b0;
    #1;
    expect_val("tx_valid_in_reset", 32'd0); check({31'b0, tx_valid});
    @(negedge clk); rst_n = 1'b1;
    load_check("status_after_reset", STS, 32'h0000_0006);
    load_check("ram_after_reset", 32'h10, 32'hDEAD55EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
# data_memory_mmio

Byte-addressable data memory for the single-cycle RISC-V core with a memory-mapped UART window backed by TX and RX FIFOs. It replaces ad-hoc UART strobes with a valid/ready TX stream, a buffered RX stream, a status/clear register and misalignment detection. It sits between the core's load/store datapath and the UART TX/RX engines.

## Interface
Parameters:
- DEPTH_BYTES, 256: data RAM size in bytes; power of two, at least 8.
- ADDR_WIDTH, 32: width of `addr`.
- MMIO_BASE, 32'h0000_0400: base of the 3-word UART window; must lie outside RAM.
- TX_DEPTH, 4: TX FIFO entries; power of two, at least 2.
- RX_DEPTH, 4: RX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  store strobe, sampled at posedge.
- size  in  2  store size: 00 = byte (sb), 01 = half (sh), 10 = word (sw), 11 = reserved.
- re  in  1  load strobe; qualifies RX pop side effects.
- addr  in  ADDR_WIDTH  byte address.
- wd  in  32  store data, little-endian lanes.
- rd  out  32  combinational load data.
- tx_data  out  8  head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  UART TX accepts `tx_data` when high with `tx_valid`.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle push strobe from the UART RX engine.
- irq  out  1  level interrupt: RX not empty OR any sticky flag set.

## Operation
**Decode.** These registers are recognised only on an exact `addr` match.
- MMIO_BASE+0 is TXDATA.
- MMIO_BASE+4 is RXDATA.
- MMIO_BASE+8 is STATUS.
- Any other address inside MMIO_BASE..MMIO_BASE+11 is ignored: writes are dropped and `rd` returns 0.
- Every other address goes to RAM at index `addr mod DEPTH_BYTES`, and the four-byte read wraps around RAM.

**RAM stores.** RAM is written at posedge when `we` is high.
- sb writes lane 0.
- sh writes lanes 0–1, only if addr[0]==0.
- sw writes lanes 0–3, only if addr[1:0]==0.
- A misaligned sh or sw writes nothing and sets sticky MISALIGN.
- size==11 writes nothing and sets MISALIGN.

**RAM loads.** `rd` = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, indices mod DEPTH_BYTES. The core performs extension.

**TXDATA.**
- A store of any size to TXDATA pushes wd[7:0].
- A push while the FIFO is full sets sticky TXOVF and drops the byte, except when a pop occurs in the same cycle; then both the push and the pop proceed.
- A load of TXDATA returns 0.

**RXDATA.**
- A load returns {!rx_empty, 23'b0, head}. Bit 31 is the valid flag.
- At posedge, `re` high with addr==RXDATA and RX not empty pops one entry.
- A store to RXDATA is ignored.

**RX push.**
- `rx_valid` pushes `rx_data`.
- A push while the FIFO is full with no pop in the same cycle drops the byte and sets sticky RXOVR.
- A push and a pop in the same cycle both proceed.

**STATUS.**
- Read bits: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] TXOVF, [5] RXOVR, [6] MISALIGN, [15:8] rx_count, [31:16] 0.
- A store writes 1-to-clear to bits [6:4].
- A flag being set and cleared in the same cycle ends set.

**TX stream.**
- `tx_valid` = !tx_empty and `tx_data` = the FIFO head.
- The FIFO pops at posedge when `tx_valid` and `tx_ready` are both high.

## Timing
- Reset (asynchronous assertion, synchronous release via rst_n):
  - Both FIFOs are empty, with pointers and counts at 0.
  - Stickies are 0.
  - Outputs: `tx_valid`=0, `tx_data`=0, `irq`=0.
  - `rd` shows RAM or STATUS = 32'h0000_0006.
  - RAM contents are not reset.
- Resetting mid-operation discards all FIFO contents. RAM is unchanged.
- A store to TXDATA at edge N gives `tx_valid`=1 in the cycle after N. A handshake at edge M removes the entry at M.
- `rx_valid` at edge N makes the byte readable at RXDATA in cycle N+1. `irq` rises in cycle N+1.
- `rd` is combinational with zero latency. FIFO and status changes appear after the edge.
- Pointers wrap modulo depth. Each count has $clog2(depth)+1 bits.

## Structure
- Shared package `dmem_pkg` holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - register offsets OFF_TXDATA = 0, OFF_RXDATA = 4, OFF_STATUS = 8;
  - STATUS bit indices.
- Sub-module `sync_fifo` is parametrised by WIDTH and DEPTH. It has ports push, pop, din, dout (combinational head), full, empty and count. It is instantiated twice, for TX and RX. Overflow policy stays in the parent.

## Test plan
- **Word store and load:** sw 32'hDEADBEEF @0x10, then lb-read @0x10 → `rd`=32'hDEADBEEF. sb 8'h55 @0x11 → `rd`=32'hDEAD55EF.
- **Misaligned store:** sw @0x12 → RAM is unchanged, STATUS[6]=1, `irq`=1. Store 32'h40 to STATUS → STATUS[6]=0, `irq`=0.
- **TX stream:** with `tx_ready`=0, store 8'h41, 8'h42, 8'h43, 8'h44, 8'h45 → the fifth byte is dropped, STATUS[0]=1 and STATUS[4]=1. Then raise `tx_ready` → `tx_data` sequence 41, 42, 43, 44, after which `tx_valid`=0.
- **RX overrun:** pulse `rx_valid` with 8'h10..8'h14 → STATUS[15:8]=4, STATUS[5]=1. Four loads with `re`=1 from RXDATA return 32'h8000_0010..13. A fifth load returns 32'h0000_0013 with bit 31 = 0 and pops nothing.
- **Simultaneous RX:** RX full, `rx_valid`=1 with 8'h99 and an RXDATA pop in the same cycle → count stays 4, no RXOVR, 8'h99 is last out.
- **Reset mid-stream:** TX holds 3 bytes, assert rst_n low between edges → `tx_valid`=0 immediately. STATUS=32'h0000_0006 after release.
